universal_shift_register: RTL and testbench

- Parameterised universal shift register with four modes: hold, shift right, shift left and parallel load, selected per clock by a 2-bit mode code.
- Generic datapath primitive for serial/parallel conversion, used inside larger datapath and control blocks.
- Single clock domain; all state changes occur on the rising clock edge.

---
 rtl/universal_shift_register.sv | 42 ++++
 tb/tb_universal_shift_register.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit universal shift register: hold, shift right, shift left, parallel load
// Optional macro USR_SERIAL_OUT_EN adds sor/sol outputs exposing the next bits to be shifted out.
module universal_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       s,
  input  logic             lsi,
  input  logic             rsi,
  input  logic [WIDTH-1:0] din,
`ifdef USR_SERIAL_OUT_EN
  output logic             sor,
  output logic             sol,
`endif
  output logic [WIDTH-1:0] qout
);

  logic [WIDTH-1:0] q;

  // reset_n is active-high; the name is kept for compatibility with existing instantiations
  always_ff @(posedge clk) begin
    if (reset_n) begin
      q <= '0;
    end else begin
      case (s)
        2'b01:   q <= {lsi, q[WIDTH-1:1]};
        2'b10:   q <= {q[WIDTH-2:0], rsi};
        2'b11:   q <= din;
        default: q <= q;
      endcase
    end
  end

  assign qout = q;

`ifdef USR_SERIAL_OUT_EN
  assign sor = q[0];
  assign sol = q[WIDTH-1];
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed self-checking bench for universal_shift_register (WIDTH=4)
module tb_universal_shift_register;

  logic       clk;
  logic       reset_n;
  logic [1:0] s;
  logic       lsi;
  logic       rsi;
  logic [3:0] din;
  logic [3:0] qout;
`ifdef USR_SERIAL_OUT_EN
  logic       sor;
  logic       sol;
`endif

  int compared   = 0;
  int mismatched = 0;

  universal_shift_register #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s),
    .lsi     (lsi),
    .rsi     (rsi),
    .din     (din),
`ifdef USR_SERIAL_OUT_EN
    .sor     (sor),
    .sol     (sol),
`endif
    .qout    (qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then settle past it before sampling.
  task automatic step(input logic rst, input logic [1:0] mode, input logic l, input logic r,
                      input logic [3:0] d);
    reset_n = rst;
    s       = mode;
    lsi     = l;
    rsi     = r;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic [3:0] exp);
    compared++;
    assert (qout === exp)
    else begin
      mismatched++;
      $error("FAIL %s: qout=%b expected=%b", tag, qout, exp);
    end
  endtask

`ifdef USR_SERIAL_OUT_EN
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b1;
    s       = 2'b00;
    lsi     = 1'b0;
    rsi     = 1'b0;
    din     = 4'b0000;
    #2;

    // Reset, then reset winning over a simultaneous parallel load
    step(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
    check_q("reset_initial", 4'b0000);
`ifdef USR_SERIAL_OUT_EN
    check_bit("sor_after_reset", sor, 1'b0);
    check_bit("sol_after_reset", sol, 1'b0);
`endif
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
    check_q("load_1011", 4'b1011);
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1111);
    check_q("reset_over_load", 4'b0000);

    // Hold ignores serial inputs and din
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
    check_q("hold_preload", 4'b1010);
    step(1'b0, 2'b00, 1'b1, 1'b1, 4'b0101);
    check_q("hold_1", 4'b1010);
    step(1'b0, 2'b00, 1'b1, 1'b1, 4'b1010);
    check_q("hold_2", 4'b1010);
    step(1'b0, 2'b00, 1'b1, 1'b1, 4'b0101);
    check_q("hold_3", 4'b1010);

    // Right shift from zero, lsi feeds the MSB, din ignored
    step(1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
    check_q("reset_before_right", 4'b0000);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'b0110);
    check_q("right_1", 4'b1000);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'b0110);
    check_q("right_2", 4'b1100);
    step(1'b0, 2'b01, 1'b1, 1'b1, 4'b0110);
    check_q("right_3", 4'b1110);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'b0110);
    check_q("right_4", 4'b1111);
    step(1'b0, 2'b01, 1'b0, 1'b1, 4'b0110);
    check_q("right_lsi0", 4'b0111);

    // Left shift, rsi feeds the LSB, MSB discarded
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
    check_q("left_preload", 4'b1010);
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'b1111);
    check_q("left_rsi1", 4'b0101);
    step(1'b0, 2'b10, 1'b1, 1'b0, 4'b1111);
    check_q("left_rsi0_a", 4'b1010);
    step(1'b0, 2'b10, 1'b1, 1'b0, 4'b1111);
    check_q("left_rsi0_b", 4'b0100);

    // Load followed by back-to-back mode switches
    step(1'b0, 2'b11, 1'b1, 1'b1, 4'b1010);
    check_q("switch_load", 4'b1010);
    step(1'b0, 2'b01, 1'b0, 1'b1, 4'b0000);
    check_q("switch_right", 4'b0101);
    step(1'b0, 2'b10, 1'b1, 1'b1, 4'b0000);
    check_q("switch_left", 4'b1011);

`ifdef USR_SERIAL_OUT_EN
    step(1'b0, 2'b11, 1'b0, 1'b0, 4'b1001);
    check_q("serial_load", 4'b1001);
    check_bit("sor_load", sor, 1'b1);
    check_bit("sol_load", sol, 1'b1);
    step(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000);
    check_q("serial_right", 4'b0100);
    check_bit("sor_right", sor, 1'b0);
    check_bit("sol_right", sol, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
